// File: rtl/id_ex_dm_datapath_pkg.sv
// Shared constants for the ID/EX/DM datapath: ALU function codes, RV32I
// opcodes and the sign-extension helper used by the immediate generators.
package id_ex_dm_datapath_pkg;

    // ALU function select codes; every other code yields z = 0
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // RV32I major opcodes (ins[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_OP     = 7'h33;

    // Sign-extend a 12-bit immediate field to 32 bits
    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/id_ex_dm_datapath_if.sv
// Bundle of the datapath's control, instruction and result signals.
// master = the surrounding control/fetch/write-back logic, slave = datapath.
interface id_ex_dm_datapath_if;

    logic [31:0] ins;
    logic [31:0] wd;
    logic        reg_write;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        mem_read;
    logic        mem_write;

    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] j_target;
    logic [31:0] branch;
    logic [31:0] z;
    logic        zero;
    logic [31:0] mem_out;

    modport master (
        output ins, wd, reg_write, alu_src, alu_op, mem_read, mem_write,
        input  rd1, rd2, imm, j_target, branch, z, zero, mem_out
    );

    modport slave (
        input  ins, wd, reg_write, alu_src, alu_op, mem_read, mem_write,
        output rd1, rd2, imm, j_target, branch, z, zero, mem_out
    );

endinterface

// File: rtl/id_ex_dm_datapath_reg_file_32x32.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, synchronous clear. x0 ignores writes and always reads as zero.
module reg_file_32x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [32];

    // Clear all registers on reset (reset wins over a write), else write port
    always_ff @(posedge clk) begin
        // NOTE: non-blocking (<=) for every state update so all flops sample
        // pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous reads with no write bypass; x0 forced to zero
    always_comb begin
        rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];
    end

endmodule

// File: rtl/id_ex_dm_datapath.sv
// Single-cycle RV32I decode/execute/memory datapath. Control is supplied
// externally; this block holds the register file, immediate generators,
// ALU and a word-addressed data memory, all producing same-cycle results.
module id_ex_dm_datapath
    import id_ex_dm_datapath_pkg::*;
#(
    parameter int DM_WORDS = 256
) (
    input logic                 clk,
    input logic                 rst,
    id_ex_dm_datapath_if.slave  dp
);

    localparam int AW = $clog2(DM_WORDS);

    logic [31:0]   rd1;
    logic [31:0]   rd2;
    logic [31:0]   imm;
    logic [31:0]   alu_b;
    logic [31:0]   z;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dmem_q [DM_WORDS];

    reg_file_32x32 u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (dp.reg_write),
        .waddr_i  (dp.ins[11:7]),
        .wdata_i  (dp.wd),
        .raddr1_i (dp.ins[19:15]),
        .raddr2_i (dp.ins[24:20]),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Immediate generators: I/S immediate plus branch and jump offsets
    always_comb begin
        if (dp.ins[6:0] == OPC_STORE) begin
            imm = sext12({dp.ins[31:25], dp.ins[11:7]});
        end else begin
            imm = sext12(dp.ins[31:20]);
        end
        dp.branch   = {{19{dp.ins[31]}}, dp.ins[31], dp.ins[7],
                       dp.ins[30:25], dp.ins[11:8], 1'b0};
        dp.j_target = {{11{dp.ins[31]}}, dp.ins[31], dp.ins[19:12],
                       dp.ins[20], dp.ins[30:21], 1'b0};
    end

    // ALU: operand B muxed between rd2 and imm; unknown codes give zero
    always_comb begin
        // NOTE: z gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        z     = 32'd0;
        alu_b = dp.alu_src ? imm : rd2;
        case (dp.alu_op)
            ALU_AND: z = rd1 & alu_b;
            ALU_OR:  z = rd1 | alu_b;
            ALU_ADD: z = rd1 + alu_b;
            ALU_SUB: z = rd1 - alu_b;
            ALU_SLT: z = {31'd0, ($signed(rd1) < $signed(alu_b))};
            default: z = 32'd0;
        endcase
    end

    // Word address from the ALU result; byte offset and high bits dropped
    assign dm_addr = z[AW+1:2];

    // Data memory write port; reset blocks writes but never clears contents
    always_ff @(posedge clk) begin
        // NOTE: the memory array is deliberately not reset so it maps onto
        // RAM macros; contents are undefined until written.
        if (!rst && dp.mem_write) begin
            dmem_q[dm_addr] <= rd2;
        end
    end

    // Drive results back through the interface
    always_comb begin
        dp.rd1     = rd1;
        dp.rd2     = rd2;
        dp.imm     = imm;
        dp.z       = z;
        dp.zero    = (z == 32'd0);
        dp.mem_out = dp.mem_read ? dmem_q[dm_addr] : 32'd0;
    end

endmodule

// File: tb/tb_id_ex_dm_datapath.sv
// Directed self-checking bench for id_ex_dm_datapath.
module tb_id_ex_dm_datapath;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    id_ex_dm_datapath_if dp_if ();

    id_ex_dm_datapath #(.DM_WORDS(256)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        dp_if.ins       = 32'h0000_0013;
        dp_if.wd        = 32'd0;
        dp_if.reg_write = 1'b0;
        dp_if.alu_src   = 1'b0;
        dp_if.alu_op    = 3'b010;
        dp_if.mem_read  = 1'b0;
        dp_if.mem_write = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        idle();
        dp_if.ins       = {20'd0, rd, 7'h13};
        dp_if.wd        = val;
        dp_if.reg_write = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dp_if.ins = 32'h0062_8033;      // rs1=x5, rs2=x6
        #1;
        cmp("reset_rd1_x5", dp_if.rd1, 32'd0);
        cmp("reset_rd2_x6", dp_if.rd2, 32'd0);
        cmp("reset_mem_out_idle", dp_if.mem_out, 32'd0);
    endtask

    task automatic test_addi();
        idle();
        dp_if.ins     = 32'h0070_0293;  // addi x5,x0,7
        dp_if.alu_src = 1'b1;
        dp_if.alu_op  = 3'b010;
        #1;
        cmp("addi_imm", dp_if.imm, 32'd7);
        cmp("addi_rd1", dp_if.rd1, 32'd0);
        cmp("addi_z", dp_if.z, 32'd7);
        cmp("addi_zero", {31'd0, dp_if.zero}, 32'd0);
        dp_if.wd        = 32'd7;
        dp_if.reg_write = 1'b1;
        step();
        idle();
        dp_if.ins = 32'h0002_8013;      // addi x0,x5,0 -> reads x5
        #1;
        cmp("addi_x5_after", dp_if.rd1, 32'd7);
    endtask

    task automatic test_store_load();
        idle();
        dp_if.ins       = 32'h0050_2423; // sw x5,8(x0)
        dp_if.alu_src   = 1'b1;
        dp_if.alu_op    = 3'b010;
        dp_if.mem_write = 1'b1;
        #1;
        cmp("sw_imm", dp_if.imm, 32'd8);
        cmp("sw_z", dp_if.z, 32'd8);
        cmp("sw_rd2", dp_if.rd2, 32'd7);
        step();
        dp_if.mem_write = 1'b0;
        dp_if.mem_read  = 1'b1;
        #1;
        cmp("lw_after_sw", dp_if.mem_out, 32'd7);
        dp_if.mem_read = 1'b0;
        #1;
        cmp("mem_read_off", dp_if.mem_out, 32'd0);
        dp_if.mem_read = 1'b1;
        dp_if.ins      = 32'h00A0_2003; // lw x0,10(x0): byte offset ignored
        #1;
        cmp("lw_byte_offset", dp_if.mem_out, 32'd7);
        dp_if.ins      = 32'h4080_2003; // lw x0,1032(x0): wraps to word 2
        #1;
        cmp("lw_wrap", dp_if.mem_out, 32'd7);
        idle();
    endtask

    task automatic test_alu();
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd5);
        write_reg(5'd3, 32'hFFFF_FFFF);
        dp_if.alu_src = 1'b0;
        dp_if.ins     = 32'h0020_8033;  // rs1=x1, rs2=x2
        dp_if.alu_op  = 3'b110;
        #1;
        cmp("sub_z", dp_if.z, 32'd0);
        cmp("sub_zero", {31'd0, dp_if.zero}, 32'd1);
        dp_if.ins    = 32'h0011_8033;   // rs1=x3(-1), rs2=x1(5)
        dp_if.alu_op = 3'b111;
        #1;
        cmp("slt_neg_lt_pos", dp_if.z, 32'd1);
        dp_if.alu_op = 3'b011;
        #1;
        cmp("undef_op_z", dp_if.z, 32'd0);
        dp_if.alu_op = 3'b000;
        #1;
        cmp("and_z", dp_if.z, 32'd5);
        dp_if.alu_op = 3'b001;
        #1;
        cmp("or_z", dp_if.z, 32'hFFFF_FFFF);
        dp_if.alu_op = 3'b010;
        #1;
        cmp("add_wrap", dp_if.z, 32'd4);
        cmp("add_zero_flag", {31'd0, dp_if.zero}, 32'd0);
        dp_if.ins    = 32'h0030_8033;   // rs1=x1(5), rs2=x3(-1)
        dp_if.alu_op = 3'b111;
        #1;
        cmp("slt_pos_vs_neg", dp_if.z, 32'd0);
        dp_if.alu_op = 3'b110;
        #1;
        cmp("sub_5_minus_neg1", dp_if.z, 32'd6);
        idle();
    endtask

    task automatic test_imm();
        idle();
        dp_if.ins = 32'hFE00_0EE3;      // beq x0,x0,-4
        #1;
        cmp("beq_branch", dp_if.branch, 32'hFFFF_FFFC);
        cmp("beq_i_imm", dp_if.imm, 32'hFFFF_FFE0);
        dp_if.ins = 32'hFF9F_F06F;      // jal x0,-8
        #1;
        cmp("jal_target", dp_if.j_target, 32'hFFFF_FFF8);
        dp_if.ins = 32'hFE50_2E23;      // sw x5,-4(x0)
        #1;
        cmp("sw_neg_imm", dp_if.imm, 32'hFFFF_FFFC);
        idle();
    endtask

    task automatic test_x0();
        write_reg(5'd0, 32'h55);
        dp_if.ins = 32'h0000_0033;      // rs1=rs2=x0
        #1;
        cmp("x0_rd1", dp_if.rd1, 32'd0);
        cmp("x0_rd2", dp_if.rd2, 32'd0);
    endtask

    task automatic test_reset_keeps_mem();
        idle();
        dp_if.ins       = 32'h0000_0293; // rd = x5
        dp_if.wd        = 32'h99;
        dp_if.reg_write = 1'b1;
        rst             = 1'b1;
        step();
        rst = 1'b0;
        idle();
        dp_if.ins = 32'h0002_8013;      // read x5
        #1;
        cmp("rst_over_write_x5", dp_if.rd1, 32'd0);
        dp_if.ins      = 32'h0080_2003; // lw x0,8(x0)
        dp_if.alu_src  = 1'b1;
        dp_if.mem_read = 1'b1;
        #1;
        cmp("rst_mem_kept", dp_if.mem_out, 32'd7);
        idle();
    endtask

    task automatic test_back_to_back();
        write_reg(5'd6, 32'h55);
        dp_if.ins       = 32'h0060_2423; // sw x6,8(x0)
        dp_if.alu_src   = 1'b1;
        dp_if.alu_op    = 3'b010;
        dp_if.mem_write = 1'b1;
        dp_if.mem_read  = 1'b1;
        #1;
        cmp("rdw_old_word", dp_if.mem_out, 32'd7);
        step();
        dp_if.mem_write = 1'b0;
        #1;
        cmp("rdw_new_word", dp_if.mem_out, 32'h55);
        idle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        idle();
        step();
        test_reset();
        test_addi();
        test_store_load();
        test_alu();
        test_imm();
        test_x0();
        test_reset_keeps_mem();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
